// File: rtl/score_keeper.sv
// score_keeper: game FSM with saturating BCD score, high score and frame-skip speed-up
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   frame_tick   one-cycle pulse per frame
//   start        starts or restarts a game
//   collision    ends the running game
//   score_bcd    current score, 4 BCD digits, [3:0] = ones
//   hiscore_bcd  best score since reset, 4 BCD digits
//   skip         frame-skip value for the skip counter
//   running      high in RUN
//   game_over    high in OVER
//   new_record   high in OVER when the last game beat the high score
module score_keeper #(
    parameter int          TICKS_PER_POINT = 6,
    parameter logic [3:0]  INIT_SKIP       = 4'd3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        collision,
    output logic [15:0] score_bcd,
    output logic [15:0] hiscore_bcd,
    output logic [3:0]  skip,
    output logic        running,
    output logic        game_over,
    output logic        new_record
);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    localparam logic [3:0] SUB_INIT = 4'(TICKS_PER_POINT - 1);
    state_t      state_q;
    logic [15:0] score_q, hiscore_q, score_d;
    logic [3:0]  skip_q, sub_q;
    logic        running_q, game_over_q, new_record_q;
    logic        carry, sat, hundred;
    // BCD ripple increment: a 9 rolls to 0 and passes the carry upward
    always_comb begin
        score_d = score_q;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            score_d[4*i +: 4] = carry ? (score_q[4*i +: 4] == 4'd9 ? 4'd0 : score_q[4*i +: 4] + 4'd1) : score_q[4*i +: 4];
            carry = carry && (score_q[4*i +: 4] == 4'd9);
        end
    end
    assign sat     = score_q == 16'h9999;
    assign hundred = score_d[7:0] == 8'h00;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            score_q      <= '0;
            hiscore_q    <= '0;
            skip_q       <= INIT_SKIP;
            sub_q        <= SUB_INIT;
            running_q    <= 1'b0;
            game_over_q  <= 1'b0;
            new_record_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (collision) begin
                        state_q     <= OVER;
                        running_q   <= 1'b0;
                        game_over_q <= 1'b1;
                        if (score_q > hiscore_q) begin
                            hiscore_q    <= score_q;
                            new_record_q <= 1'b1;
                        end else begin
                            new_record_q <= 1'b0;
                        end
                    end else if (frame_tick) begin
                        if (sub_q == 4'd0) begin
                            sub_q <= SUB_INIT;
                            if (!sat) begin
                                score_q <= score_d;
                                if (hundred && skip_q != 4'd0) skip_q <= skip_q - 4'd1;
                            end
                        end else begin
                            sub_q <= sub_q - 4'd1;
                        end
                    end
                end
                default: begin
                    // IDLE and OVER both start a fresh game on start
                    if (start) begin
                        state_q      <= RUN;
                        running_q    <= 1'b1;
                        game_over_q  <= 1'b0;
                        score_q      <= '0;
                        sub_q        <= SUB_INIT;
                        skip_q       <= INIT_SKIP;
                        new_record_q <= 1'b0;
                    end
                end
            endcase
        end
    end
    assign score_bcd   = score_q;
    assign hiscore_bcd = hiscore_q;
    assign skip        = skip_q;
    assign running     = running_q;
    assign game_over   = game_over_q;
    assign new_record  = new_record_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for two score_keeper instances (6 and 1 ticks per point)
module tb_score_keeper;
    logic clk, resetn, frame_tick, start, collision;
    logic [15:0] sc[2], hs[2];
    logic [3:0]  sk[2];
    logic        rn[2], go[2], nr[2];

    score_keeper #(.TICKS_PER_POINT(6), .INIT_SKIP(4'd3)) dut0 (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start), .collision(collision),
        .score_bcd(sc[0]), .hiscore_bcd(hs[0]), .skip(sk[0]), .running(rn[0]), .game_over(go[0]), .new_record(nr[0])
    );
    score_keeper #(.TICKS_PER_POINT(1), .INIT_SKIP(4'd3)) dut1 (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start), .collision(collision),
        .score_bcd(sc[1]), .hiscore_bcd(hs[1]), .skip(sk[1]), .running(rn[1]), .game_over(go[1]), .new_record(nr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [15:0] sc;
        logic [15:0] hs;
        logic [3:0]  sk;
        logic        rn;
        logic        go;
        logic        nr;
    } exp_t;

    exp_t q[2][$];
    int vecs = 0;
    int errs = 0;

    // reference model: plain integers, state as 0=idle 1=run 2=over
    int tpp[2] = '{6, 1};
    int m_st[2], m_score[2], m_hi[2], m_skip[2], m_sub[2];
    bit m_nr[2];

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic new_game(int k);
        m_st[k] = 1;
        m_score[k] = 0;
        m_sub[k] = tpp[k] - 1;
        m_skip[k] = 3;
        m_nr[k] = 0;
    endtask

    task automatic model_step(int k, bit r, bit s, bit c, bit t);
        if (!r) begin
            m_st[k] = 0; m_score[k] = 0; m_hi[k] = 0; m_skip[k] = 3; m_sub[k] = tpp[k] - 1; m_nr[k] = 0;
        end else if (m_st[k] == 1) begin
            if (c) begin
                m_st[k] = 2;
                m_nr[k] = m_score[k] > m_hi[k];
                if (m_nr[k]) m_hi[k] = m_score[k];
            end else if (t) begin
                if (m_sub[k] == 0) begin
                    m_sub[k] = tpp[k] - 1;
                    if (m_score[k] < 9999) begin
                        m_score[k]++;
                        if (m_score[k] % 100 == 0 && m_skip[k] > 0) m_skip[k]--;
                    end
                end else begin
                    m_sub[k]--;
                end
            end
        end else if (s) begin
            new_game(k);
        end
    endtask

    task automatic cyc(bit r, bit s, bit c, bit t);
        exp_t e;
        @(negedge clk);
        resetn = r; start = s; collision = c; frame_tick = t;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, s, c, t);
            e.sc = to_bcd(m_score[k]);
            e.hs = to_bcd(m_hi[k]);
            e.sk = 4'(m_skip[k]);
            e.rn = m_st[k] == 1;
            e.go = m_st[k] == 2;
            e.nr = m_nr[k];
            q[k].push_back(e);
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 1);
    endtask

    task automatic chk(string nm, int k, logic [15:0] act, logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // monitor: one expected bundle per clock edge, checked just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (q[k].size() > 0) begin
                    e = q[k].pop_front();
                    chk("score", k, sc[k], e.sc);
                    chk("hiscore", k, hs[k], e.hs);
                    chk("skip", k, 16'(sk[k]), 16'(e.sk));
                    chk("running", k, 16'(rn[k]), 16'(e.rn));
                    chk("game_over", k, 16'(go[k]), 16'(e.go));
                    chk("new_record", k, 16'(nr[k]), 16'(e.nr));
                end
            end
        end
    end

    initial begin
        resetn = 1'b0; start = 1'b0; collision = 1'b0; frame_tick = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 1);
        // idle ignores ticks and collisions
        cyc(1, 0, 1, 1);
        cyc(1, 0, 0, 1);
        // start, 12 ticks, then run through several hundreds for the skip floor
        cyc(1, 1, 0, 0);
        ticks(12);
        ticks(2400 - 12);
        cyc(1, 0, 1, 0);
        // high score sequence: 41 with collision on a scoring tick, then 30, then a tie at 41
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        ticks(251);
        cyc(1, 0, 1, 1);
        cyc(1, 1, 1, 0);
        ticks(180);
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 1);
        ticks(244);
        cyc(1, 0, 1, 0);
        // game to 100, then mid-run reset at 250
        cyc(1, 1, 0, 0);
        ticks(600);
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        ticks(1500);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        // randomized play
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 999) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1);
        // long game: the single-tick instance saturates at 9999
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        ticks(10012);
        cyc(1, 0, 1, 1);
        cyc(1, 1, 0, 0);
        ticks(20);
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && (q[0].size() > 0 || q[1].size() > 0); i++) @(posedge clk);
        #2;
        if (q[0].size() > 0 || q[1].size() > 0) begin
            errs++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q[0].size(), q[1].size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
